// File: rtl/wb_csr_ctrl.sv
// Write-back stage: commits CSR ops, exceptions, interrupts and ERTN,
// and holds a redirect request to IF until it is acknowledged.
module wb_csr_ctrl #(
    parameter logic [5:0]  ECODE_INT = 6'h00,
    parameter logic [31:0] PC_RESET  = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [1:0]  in_csr_op,
    input  logic [13:0] in_csr_num,
    input  logic [31:0] in_rd_value,
    input  logic [31:0] in_rj_value,
    input  logic [4:0]  in_rd,
    input  logic        in_ertn,
    input  logic        in_ex,
    input  logic [5:0]  in_ecode,
    input  logic [8:0]  in_esubcode,
    input  logic [31:0] in_vaddr,
    input  logic        has_int,
    output logic        csr_re,
    output logic [13:0] csr_num,
    input  logic [31:0] csr_rvalue,
    output logic        csr_we,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        wb_ex,
    output logic        ertn_flush,
    output logic [31:0] wb_csr_pc,
    output logic [31:0] wb_vaddr,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ertn_entry,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        flush_valid,
    output logic [31:0] flush_pc,
    input  logic        flush_ack
);

    typedef enum logic {
        S_RUN,
        S_WAIT
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  op;
        logic [13:0] num;
        logic [31:0] rd_value;
        logic [31:0] rj_value;
        logic [4:0]  rd;
        logic        ertn;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] vaddr;
    } ws_t;

    state_t      state_q;
    state_t      state_d;
    ws_t         ws_q;
    logic        ws_valid;
    logic        ws_kill;
    logic [31:0] flush_pc_q;
    logic [31:0] flush_pc_d;

    logic commit;
    logic take_exc;
    logic take_ertn;
    logic take_csr;

    assign in_ready    = 1'b1;
    assign flush_valid = (state_q == S_WAIT);
    assign flush_pc    = flush_pc_q;

    // Commit priority: exception > interrupt > ertn > csr op.
    assign commit    = ws_valid && !ws_kill && (state_q == S_RUN);
    assign take_exc  = commit && (ws_q.ex || has_int);
    assign take_ertn = commit && !take_exc && ws_q.ertn;
    assign take_csr  = commit && !take_exc && !ws_q.ertn
                       && (ws_q.op != 2'b00);

    always_comb begin
        state_d     = state_q;
        flush_pc_d  = flush_pc_q;
        csr_re      = 1'b0;
        csr_num     = 14'd0;
        csr_we      = 1'b0;
        csr_wmask   = 32'd0;
        csr_wvalue  = 32'd0;
        wb_ex       = 1'b0;
        ertn_flush  = 1'b0;
        wb_csr_pc   = 32'd0;
        wb_vaddr    = 32'd0;
        wb_ecode    = 6'd0;
        wb_esubcode = 9'd0;
        rf_we       = 1'b0;
        rf_waddr    = 5'd0;
        rf_wdata    = 32'd0;
        if (state_q == S_WAIT) begin
            if (flush_ack) state_d = S_RUN;
        end else begin
            unique case (1'b1)
                take_exc: begin
                    wb_ex      = 1'b1;
                    wb_csr_pc  = ws_q.pc;
                    state_d    = S_WAIT;
                    flush_pc_d = ex_entry;
                    if (ws_q.ex) begin
                        wb_ecode    = ws_q.ecode;
                        wb_esubcode = ws_q.esubcode;
                        wb_vaddr    = ws_q.vaddr;
                    end else begin
                        wb_ecode = ECODE_INT;
                    end
                end
                take_ertn: begin
                    ertn_flush = 1'b1;
                    state_d    = S_WAIT;
                    flush_pc_d = ertn_entry;
                end
                take_csr: begin
                    csr_re   = 1'b1;
                    csr_num  = ws_q.num;
                    rf_we    = 1'b1;
                    rf_waddr = ws_q.rd;
                    rf_wdata = csr_rvalue;
                    if (ws_q.op[1]) begin
                        csr_we     = 1'b1;
                        csr_wvalue = ws_q.rd_value;
                        csr_wmask  = ws_q.op[0] ? ws_q.rj_value
                                                : 32'hffffffff;
                        state_d    = S_WAIT;
                        flush_pc_d = ws_q.pc + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_RUN;
            flush_pc_q <= PC_RESET;
        end else begin
            state_q    <= state_d;
            flush_pc_q <= flush_pc_d;
        end
    end

    // Anything loaded while a redirect will be outstanding is wrong-path.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid <= 1'b0;
            ws_kill  <= 1'b0;
            ws_q     <= '0;
        end else if (in_valid && in_ready) begin
            ws_valid      <= 1'b1;
            ws_kill       <= (state_d == S_WAIT);
            ws_q.pc       <= in_pc;
            ws_q.op       <= in_csr_op;
            ws_q.num      <= in_csr_num;
            ws_q.rd_value <= in_rd_value;
            ws_q.rj_value <= in_rj_value;
            ws_q.rd       <= in_rd;
            ws_q.ertn     <= in_ertn;
            ws_q.ex       <= in_ex;
            ws_q.ecode    <= in_ecode;
            ws_q.esubcode <= in_esubcode;
            ws_q.vaddr    <= in_vaddr;
        end else begin
            ws_valid <= 1'b0;
            ws_kill  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_csr_ctrl.sv
// Bench for wb_csr_ctrl: directed cases then random traffic
// checked against a cycle-level reference model.
module tb_wb_csr_ctrl;

    localparam logic [31:0] PC_RESET = 32'h1c000000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [1:0]  in_csr_op;
    logic [13:0] in_csr_num;
    logic [31:0] in_rd_value;
    logic [31:0] in_rj_value;
    logic [4:0]  in_rd;
    logic        in_ertn;
    logic        in_ex;
    logic [5:0]  in_ecode;
    logic [8:0]  in_esubcode;
    logic [31:0] in_vaddr;
    logic        has_int;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic        ertn_flush;
    logic [31:0] wb_csr_pc;
    logic [31:0] wb_vaddr;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic        flush_ack;

    wb_csr_ctrl dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_csr_op(in_csr_op),
        .in_csr_num(in_csr_num), .in_rd_value(in_rd_value),
        .in_rj_value(in_rj_value), .in_rd(in_rd),
        .in_ertn(in_ertn), .in_ex(in_ex),
        .in_ecode(in_ecode), .in_esubcode(in_esubcode),
        .in_vaddr(in_vaddr), .has_int(has_int),
        .csr_re(csr_re), .csr_num(csr_num),
        .csr_rvalue(csr_rvalue), .csr_we(csr_we),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .ertn_flush(ertn_flush),
        .wb_csr_pc(wb_csr_pc), .wb_vaddr(wb_vaddr),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .ex_entry(ex_entry), .ertn_entry(ertn_entry),
        .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .flush_valid(flush_valid),
        .flush_pc(flush_pc), .flush_ack(flush_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        bit          live;
        logic [31:0] pc;
        logic [1:0]  op;
        logic [13:0] num;
        logic [31:0] rdv;
        logic [31:0] rjv;
        logic [4:0]  rd;
        logic        ertn;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] vaddr;
    } ins_t;

    ins_t        mi;
    bit          m_wait;
    logic [31:0] m_fpc;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        in_valid = 0; in_pc = 0; in_csr_op = 0; in_csr_num = 0;
        in_rd_value = 0; in_rj_value = 0; in_rd = 0; in_ertn = 0;
        in_ex = 0; in_ecode = 0; in_esubcode = 0; in_vaddr = 0;
        has_int = 0; flush_ack = 0;
    endtask

    task automatic load(input logic [31:0] pc, input logic [1:0] op,
                        input logic [13:0] num, input logic [31:0] rdv,
                        input logic [31:0] rjv, input logic ertn,
                        input logic ex, input logic [5:0] ec);
        in_valid = 1; in_pc = pc; in_csr_op = op; in_csr_num = num;
        in_rd_value = rdv; in_rj_value = rjv; in_rd = 5'd7;
        in_ertn = ertn; in_ex = ex; in_ecode = ec;
        in_esubcode = 9'h15; in_vaddr = 32'hbad0_0000 | pc;
    endtask

    task automatic model_reset();
        m_wait = 0;
        m_fpc  = PC_RESET;
        mi.v   = 0;
        mi.live = 0;
    endtask

    // Called at posedge+1 with inputs set; checks then advances one edge.
    task automatic step();
        bit          commit, exc, ert, csrc, wr, redirect;
        logic [31:0] tgt;
        #3;
        commit = mi.v && mi.live && !m_wait;
        exc    = commit && (mi.ex || has_int);
        ert    = commit && !exc && mi.ertn;
        csrc   = commit && !exc && !mi.ertn && (mi.op != 2'b00);
        wr     = csrc && mi.op[1];
        chk("in_ready", in_ready, 1);
        chk("flush_valid", flush_valid, m_wait);
        chk("flush_pc", flush_pc, m_fpc);
        chk("wb_ex", wb_ex, exc);
        chk("ertn_flush", ertn_flush, ert);
        chk("csr_re", csr_re, csrc);
        chk("csr_we", csr_we, wr);
        chk("rf_we", rf_we, csrc);
        chk("csr_num", csr_num, csrc ? mi.num : 14'd0);
        if (exc) begin
            chk("wb_csr_pc", wb_csr_pc, mi.pc);
            chk("wb_ecode", wb_ecode, mi.ex ? mi.ecode : 6'd0);
            chk("wb_esub", wb_esubcode, mi.ex ? mi.esub : 9'd0);
            chk("wb_vaddr", wb_vaddr, mi.ex ? mi.vaddr : 32'd0);
        end
        if (csrc) begin
            chk("rf_waddr", rf_waddr, mi.rd);
            chk("rf_wdata", rf_wdata, csr_rvalue);
        end
        if (wr) begin
            chk("csr_wvalue", csr_wvalue, mi.rdv);
            chk("csr_wmask", csr_wmask,
                mi.op == 2'b11 ? mi.rjv : 32'hffffffff);
        end
        @(posedge clk);
        redirect = exc || ert || wr;
        tgt = exc ? ex_entry : (ert ? ertn_entry : mi.pc + 32'd4);
        if (m_wait) begin
            if (flush_ack) m_wait = 0;
        end else if (redirect) begin
            m_wait = 1;
            m_fpc  = tgt;
        end
        mi.v = in_valid;
        mi.live = !m_wait;
        mi.pc = in_pc; mi.op = in_csr_op; mi.num = in_csr_num;
        mi.rdv = in_rd_value; mi.rjv = in_rj_value; mi.rd = in_rd;
        mi.ertn = in_ertn; mi.ex = in_ex; mi.ecode = in_ecode;
        mi.esub = in_esubcode; mi.vaddr = in_vaddr;
        #1;
    endtask

    initial begin
        resetn = 0;
        idle();
        csr_rvalue = 0;
        ex_entry = 32'h1c008000;
        ertn_entry = 32'h1c000100;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flush_valid", flush_valid, 0);
        chk("rst_flush_pc", flush_pc, PC_RESET);
        chk("rst_wb_ex", wb_ex, 0);
        resetn = 1;
        step();

        // csrrd 0x30
        load(32'h1c000000, 2'b01, 14'h30, 0, 0, 0, 0, 0);
        step();
        idle();
        csr_rvalue = 32'hdeadbeef;
        step();
        step();

        // csrxchg with redirect to pc+4, held until ack
        load(32'h1c000010, 2'b11, 14'h4, 32'hf, 32'h3, 0, 0, 0);
        step();
        idle();
        repeat (3) step();
        flush_ack = 1;
        step();
        flush_ack = 0;
        step();

        // exception over a csr write; two wrong-path instructions in WAIT
        load(32'h1c000020, 2'b10, 14'h5, 32'h1, 0, 0, 1, 6'h0b);
        step();
        idle();
        step();
        load(32'h1c000024, 2'b10, 14'h6, 32'h2, 0, 0, 0, 0);
        step();
        load(32'h1c000028, 2'b01, 14'h7, 0, 0, 1, 0, 0);
        step();
        idle();
        flush_ack = 1;
        step();
        idle();
        step();

        // interrupt takes precedence over ertn
        load(32'h1c000030, 2'b00, 0, 0, 0, 1, 0, 0);
        step();
        idle();
        has_int = 1;
        step();
        has_int = 0;
        flush_ack = 1;
        step();
        idle();

        // ertn; instruction accepted with the ack commits normally
        load(32'h1c000040, 2'b00, 0, 0, 0, 1, 0, 0);
        step();
        idle();
        step();
        step();
        load(32'h1c000100, 2'b10, 14'h9, 32'h77, 0, 0, 0, 0);
        flush_ack = 1;
        step();
        idle();
        step();
        step();

        // asynchronous reset mid-WAIT
        #2;
        resetn = 0;
        #1;
        chk("arst_flush_valid", flush_valid, 0);
        chk("arst_wb_ex", wb_ex, 0);
        chk("arst_ertn", ertn_flush, 0);
        chk("arst_csr_we", csr_we, 0);
        chk("arst_csr_re", csr_re, 0);
        chk("arst_rf_we", rf_we, 0);
        chk("arst_flush_pc", flush_pc, PC_RESET);
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1;
        load(32'h1c000200, 2'b01, 14'h30, 0, 0, 0, 0, 0);
        step();
        idle();
        step();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid    = ($urandom_range(0, 9) < 7);
            in_pc       = $urandom;
            in_csr_op   = 2'($urandom);
            in_csr_num  = 14'($urandom);
            in_rd_value = $urandom;
            in_rj_value = $urandom;
            in_rd       = 5'($urandom);
            in_ertn     = ($urandom_range(0, 9) == 0);
            in_ex       = ($urandom_range(0, 9) < 2);
            in_ecode    = 6'($urandom);
            in_esubcode = 9'($urandom);
            in_vaddr    = $urandom;
            has_int     = ($urandom_range(0, 9) == 0);
            flush_ack   = ($urandom_range(0, 9) < 3);
            csr_rvalue  = $urandom;
            ex_entry    = $urandom;
            ertn_entry  = $urandom;
            if (i % 200 == 50) in_pc = 32'hfffffffc;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/wb_csr_ctrl.md
Name: wb_csr_ctrl

Overview:
- Write-back-stage initiator for the CSR register file: commits CSR instructions, exceptions, interrupts and ERTN.
- Drives the register file's access, exception and return inputs, and consumes its read data and entry addresses.
- Issues a registered pipeline-redirect request to IF and holds it until IF acknowledges.
- Discards wrong-path instructions while a redirect is outstanding.

Parameters:
- ECODE_INT, 6'h00, ecode written for an interrupt
- PC_RESET, 32'h1c000000, pc value used for flush_pc at reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  MEM-stage instruction valid
- in_ready  out  1  WB accepts an instruction
- in_pc  in  32  instruction pc
- in_csr_op  in  2  00 none, 01 csrrd, 10 csrwr, 11 csrxchg
- in_csr_num  in  14  CSR number
- in_rd_value  in  32  write value (rd)
- in_rj_value  in  32  write mask for csrxchg
- in_rd  in  5  destination register
- in_ertn  in  1  instruction is ertn
- in_ex  in  1  upstream exception detected
- in_ecode  in  6  upstream ecode
- in_esubcode  in  9  upstream esubcode
- in_vaddr  in  32  faulting virtual address
- has_int  in  1  enabled interrupt pending, from the CSR file
- csr_re  out  1  CSR read enable
- csr_num  out  14  CSR number
- csr_rvalue  in  32  CSR read data, combinational
- csr_we  out  1  CSR write enable
- csr_wmask  out  32  CSR write mask
- csr_wvalue  out  32  CSR write value
- wb_ex  out  1  exception commit pulse
- ertn_flush  out  1  ertn commit pulse
- wb_csr_pc  out  32  pc recorded to ERA
- wb_vaddr  out  32  bad virtual address
- wb_ecode  out  6  ecode
- wb_esubcode  out  9  esubcode
- ex_entry  in  32  exception entry, from the CSR file
- ertn_entry  in  32  ERA value, from the CSR file
- rf_we  out  1  GPR write enable
- rf_waddr  out  5  GPR write address
- rf_wdata  out  32  GPR write data (old CSR value)
- flush_valid  out  1  redirect request to IF
- flush_pc  out  32  redirect target
- flush_ack  in  1  IF accepted the redirect

Behaviour:
- Stage register: ws_valid plus latched fields. Loads on in_valid && in_ready.
- in_ready is constant 1; the stage is single-cycle.
- State RUN:
  - The instruction commits in the cycle ws_valid=1.
  - Commit priority is ws_ex > has_int > ertn > csr write (op 10/11) > plain.
- Exception commit (ws_ex):
  - wb_ex=1 for exactly one cycle.
  - wb_ecode, wb_esubcode and wb_vaddr come from the latched fields.
  - wb_csr_pc = ws_pc.
  - csr_we=0 and rf_we=0.
- Interrupt commit (has_int, no ws_ex):
  - Same as an exception commit, with ecode=ECODE_INT, esubcode=0 and wb_vaddr=0.
  - The instruction is not executed.
- Exception or interrupt redirect: next state WAIT, flush_pc <= ex_entry sampled in the commit cycle.
- ERTN commit: ertn_flush=1 for one cycle, flush_pc <= ertn_entry, next state WAIT.
- CSR op commit:
  - csr_re=1 for ops 01/10/11.
  - csr_num = ws_csr_num.
  - rf_we=1, rf_waddr = ws_rd, rf_wdata = csr_rvalue (the old value) in the same cycle.
  - Ops 10/11 also drive csr_we=1 and csr_wvalue = ws_rd_value.
  - csr_wmask = 32'hffffffff for op 10 and ws_rj_value for op 11.
  - A write redirects: flush_pc <= ws_pc+4, next state WAIT.
  - A csrrd does not redirect.
- Outputs outside a commit: csr_re, csr_we, wb_ex, ertn_flush and rf_we are 0 when not committing.
  - csr_num is 0 when no CSR op is committing.
- flush_valid is registered: it is 1 in every WAIT cycle and 0 in RUN.
- State WAIT:
  - Instructions are still accepted, because in_ready=1.
  - Accepted instructions are marked killed and never commit.
  - No CSR, exception or GPR side effects occur.
  - has_int is ignored.
- WAIT exit: flush_ack=1 in a WAIT cycle gives next state RUN.
  - An instruction accepted in the same cycle as flush_ack is the first correct-path instruction and is not killed.
- Repeated flush_ack: in RUN, flush_ack is ignored.
- Back-to-back CSR writes, each separated by its own WAIT/ack, are permitted.
- Reset, when resetn=0 (asynchronous, including mid-WAIT):
  - state RUN, ws_valid 0, flush_valid 0, flush_pc PC_RESET.
  - All pulse outputs are 0.
  - The latched ws fields are cleared to 0.
- Widths: pc+4 wraps modulo 2^32.

Test Plan:
- Commit csrrd:
  - Stimulus: csr_num=0x30, csr_rvalue=0xdeadbeef.
  - Required: in the commit cycle, csr_re=1, csr_we=0, rf_we=1 and rf_wdata=0xdeadbeef. No flush_valid.
- Commit csrxchg:
  - Stimulus: pc=0x1c000010, rd_value=0x0000000f, rj_value=0x00000003.
  - Required: csr_we=1, wmask=0x3 and wvalue=0xf.
  - Next cycle: flush_valid=1 and flush_pc=0x1c000014, held until flush_ack.
- Exception commit:
  - Stimulus: in_ex with ecode=0x0b, pc=0x1c000020, ex_entry=0x1c008000, plus a CSR write op.
  - Required: wb_ex=1 for one cycle, wb_csr_pc=0x1c000020 and csr_we=0.
  - Then flush_pc=0x1c008000.
  - Two instructions accepted during WAIT cause no csr/rf activity.
- Interrupt precedence:
  - Stimulus: has_int=1 while an ertn is in WB.
  - Required: wb_ex=1, ecode=0, ertn_flush=0.
- ERTN:
  - Stimulus: ertn_entry=0x1c000100.
  - Required: ertn_flush pulse, then flush_pc=0x1c000100.
  - An instruction accepted in the flush_ack cycle commits normally afterwards.
- Reset in WAIT:
  - Stimulus: assert resetn=0 asynchronously mid-cycle.
  - Required: flush_valid drops immediately and all pulse outputs are 0. After release, the state is RUN.
